acc_cpu_core: RTL and testbench

//  Parametrised accumulator RISC core, successor to the 5-bit/8-bit single-accumulator CPU.

---
 rtl/acc_cpu_pkg.sv | 21 ++
 rtl/acc_cpu_alu.sv | 25 ++
 rtl/acc_cpu_core.sv | 135 +++++++++++++
 tb/tb_acc_cpu_core.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared opcode encodings and FSM state type for the accumulator core.
// Opcode sits in the top 3 bits of the instruction word.
package acc_cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: result = f(opcode, acc, rdata); zero latency, no handshake.
// STO and non-ALU opcodes pass the accumulator through unchanged.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_result
);

    always_comb begin
        o_result = i_acc;
        case (i_op)
            OP_ADD:  o_result = i_acc + i_rdata;   // carry out dropped
            OP_AND:  o_result = i_acc & i_rdata;
            OP_XOR:  o_result = i_acc ^ i_rdata;
            OP_LDA:  o_result = i_rdata;
            default: o_result = i_acc;
        endcase
    end

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU tile: FETCH/DECODE/EXEC FSM, 3 cycles ALU/LDA/STO, 2 cycles SKZ/JMP at zero wait;
// memory stalls hold req/we/addr/wdata stable until ack. ACC_CPU_PERF_EN adds instr_cnt.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
`ifdef ACC_CPU_PERF_EN
   ,output logic [31:0]       instr_cnt
`endif
);

    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] w_ir_nxt;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_acc_nxt;
    logic [DATA_W-1:0] w_alu_res;
    logic [2:0]        w_opcode;
    logic [ADDR_W-1:0] w_operand;
    logic              w_done;

    assign w_opcode  = r_ir[DATA_W-1 -: 3];
    assign w_operand = r_ir[ADDR_W-1:0];
    assign w_done    = mem_req & mem_ack;

    acc_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op     (w_opcode),
        .i_acc    (r_acc),
        .i_rdata  (mem_rdata),
        .o_result (w_alu_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_acc_nxt   = r_acc;
        case (r_state)
            ST_FETCH: begin
                if (w_done) begin
                    w_ir_nxt    = mem_rdata;
                    w_pc_nxt    = r_pc + PC_INC;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (w_opcode)
                    OP_HLT: w_state_nxt = ST_HALTED;
                    OP_SKZ: begin
                        if (r_acc == '0) begin
                            w_pc_nxt = r_pc + PC_INC;
                        end
                        w_state_nxt = ST_FETCH;
                    end
                    OP_JMP: begin
                        w_pc_nxt    = w_operand;
                        w_state_nxt = ST_FETCH;
                    end
                    default: w_state_nxt = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                if (w_done) begin
                    w_acc_nxt   = w_alu_res;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_HALTED;
        endcase
    end

    // Reset drops any outstanding request immediately, not at the next edge.
    assign mem_req   = ~rst & ((r_state == ST_FETCH) | (r_state == ST_EXEC));
    assign mem_we    = (r_state == ST_EXEC) & (w_opcode == OP_STO);
    assign mem_addr  = (r_state == ST_EXEC) ? w_operand : r_pc;
    assign mem_wdata = r_acc;
    assign acc_out   = r_acc;
    assign pc_out    = r_pc;
    assign halted    = (r_state == ST_HALTED);

`ifdef ACC_CPU_PERF_EN
    logic        w_retire;
    logic [31:0] r_instr_cnt;

    assign w_retire = ((r_state == ST_DECODE) &
                       ((w_opcode == OP_HLT) | (w_opcode == OP_SKZ) | (w_opcode == OP_JMP))) |
                      ((r_state == ST_EXEC) & w_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_cnt <= '0;
        end else if (w_retire) begin
            r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: ISA-level interpreter predicts the bus transaction stream and final state.
module tb_acc_cpu_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_req, mem_we, halted;
    logic [4:0] mem_addr, pc_out;
    logic [7:0] mem_wdata, acc_out;
`ifdef ACC_CPU_PERF_EN
    logic [31:0] instr_cnt;
`endif

    always #5 clk = ~clk;

    acc_cpu_core #(.DATA_W(8), .ADDR_W(5), .RESET_PC(5'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .acc_out   (acc_out),
        .pc_out    (pc_out),
        .halted    (halted)
`ifdef ACC_CPU_PERF_EN
       ,.instr_cnt (instr_cnt)
`endif
    );

    typedef struct packed {
        logic [4:0] addr;
        logic       we;
        logic [7:0] wdata;
        logic [4:0] pc;
    } txn_t;

    int         total = 0;
    int         bad = 0;
    logic [7:0] tmem [32];
    logic [7:0] prog [32];
    logic [7:0] m_mem [32];
    logic [7:0] m_acc;
    int         m_cyc, m_ret;
    bit         m_halts;
    txn_t       exp_q [$];
    logic [4:0] log_addr [$];
    logic [7:0] log_acc [$];
    int         wait_mode = 0;
    bit         chk_on = 1'b0;
    int         waits = 0;
    int         wcnt = 0;
    int         tgt = 0;
    bit         pend = 1'b0;
    logic       pend_we, lat_we;
    logic [4:0] pend_addr, lat_addr;
    logic [7:0] pend_wdata, lat_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic int pick_wait();
        return (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
    endfunction

    // Instruction-level interpreter over a private copy of memory.
    function automatic void run_model(input int max_instr);
        logic [4:0] pc, a;
        logic [7:0] ir, acc;
        logic [2:0] op;
        bit         stop;
        pc = 5'd0; acc = 8'd0; m_cyc = 0; m_ret = 0; m_halts = 1'b0; stop = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) m_mem[i] = tmem[i];
        for (int n = 0; n < max_instr && !stop; n++) begin
            exp_q.push_back('{addr: pc, we: 1'b0, wdata: acc, pc: pc});
            ir = m_mem[pc]; pc = pc + 5'd1; op = ir[7:5]; a = ir[4:0]; m_ret++;
            if (op == 3'd0) begin
                m_cyc += 2; m_halts = 1'b1; stop = 1'b1;
            end else if (op == 3'd1) begin
                m_cyc += 2;
                if (acc == 8'd0) pc = pc + 5'd1;
            end else if (op == 3'd7) begin
                m_cyc += 2; pc = a;
            end else begin
                m_cyc += 3;
                exp_q.push_back('{addr: a, we: (op == 3'd6), wdata: acc, pc: pc});
                case (op)
                    3'd2:    acc = acc + m_mem[a];
                    3'd3:    acc = acc & m_mem[a];
                    3'd4:    acc = acc ^ m_mem[a];
                    3'd5:    acc = m_mem[a];
                    default: m_mem[a] = acc;
                endcase
            end
        end
        m_acc = acc;
    endfunction

    // Memory responder and per-transaction compare against the model stream.
    always @(negedge clk) begin
        txn_t t;
        if (pend && pend_we) tmem[pend_addr] = pend_wdata;
        if (pend) begin
            wcnt = 0;
            tgt = pick_wait();
        end
        pend = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 8'($urandom);
        if (!mem_req) begin
            wcnt = 0;
        end else begin
            if (wcnt > 0) begin
                if (chk_on) check("hold", {mem_addr, mem_we, mem_wdata}, {lat_addr, lat_we, lat_wdata});
            end else begin
                lat_addr = mem_addr; lat_we = mem_we; lat_wdata = mem_wdata;
            end
            if (wcnt >= tgt) begin
                mem_ack = 1'b1;
                mem_rdata = tmem[mem_addr];
                pend = 1'b1; pend_we = mem_we; pend_addr = mem_addr; pend_wdata = mem_wdata;
                log_addr.push_back(mem_addr);
                log_acc.push_back(acc_out);
                if (chk_on) begin
                    if (exp_q.size() == 0) begin
                        if (m_halts) begin
                            total++; bad++;
                            $display("FAIL extra_req: request at %0h after expected halt", mem_addr);
                        end
                    end else begin
                        t = exp_q.pop_front();
                        check("txn", {mem_addr, mem_we, mem_wdata, pc_out, acc_out}, {t, t.wdata});
                    end
                end
            end else begin
                wcnt++;
                waits++;
            end
        end
    end

    // Hold reset for two edges, load the program, arm the model, release.
    task automatic start(input int wmode, input int max_instr);
        chk_on = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst_req", mem_req, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) tmem[i] = prog[i];
        wait_mode = wmode;
        wcnt = 0;
        tgt = pick_wait();
        run_model(max_instr);
        waits = 0;
        log_addr.delete();
        log_acc.delete();
        chk_on = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        #1;
    endtask

    task automatic run_to_end(output int cyc);
        int nmis;
        cyc = 0;
        while (cyc < 2000 && !(exp_q.size() == 0 && (!m_halts || halted === 1'b1))) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 2000) begin
            total++; bad++;
            $display("FAIL timeout: %0d transactions still pending", exp_q.size());
        end
        if (m_halts) begin
            check("halted", halted, 1'b1);
            check("final_acc", acc_out, m_acc);
            check("cycles", cyc, m_cyc + waits);
            nmis = 0;
            for (int i = 0; i < 32; i++) if (tmem[i] !== m_mem[i]) nmis++;
            check("mem_image", nmis, 0);
`ifdef ACC_CPU_PERF_EN
            check("instr_cnt", instr_cnt, m_ret);
`endif
        end
    endtask

    task automatic load_prog2();
        for (int i = 0; i < 32; i++) prog[i] = 8'h00;
        prog[0] = 8'hBE; prog[1] = 8'h5F; prog[2] = 8'hDD; prog[3] = 8'h00;
        prog[30] = 8'h12; prog[31] = 8'h34;
    endtask

    initial begin
        int         cyc;
        logic [4:0] exp_path [9];
        bit         found;

        // Reset state and the worked store program at zero wait.
        load_prog2();
        start(0, 50);
        check("post_rst_req", mem_req, 1'b1);
        check("post_rst_addr", mem_addr, 5'h00);
        check("post_rst_acc", acc_out, 8'h00);
        check("post_rst_halt", halted, 1'b0);
        check("model_acc", m_acc, 8'h46);
        check("model_mem1d", m_mem[29], 8'h46);
        check("model_cyc", m_cyc, 11);
        run_to_end(cyc);
        check("p2_cycles", cyc, 11);
        check("p2_acc", acc_out, 8'h46);
        check("p2_mem1d", tmem[29], 8'h46);

        // Same program with three wait cycles on every access.
        load_prog2();
        start(3, 50);
        run_to_end(cyc);
        check("p3_cycles", cyc, 32);
        check("p3_acc", acc_out, 8'h46);
        check("p3_mem1d", tmem[29], 8'h46);

        // SKZ taken/not taken, JMP, PC wrap from 1F to 00.
        for (int i = 0; i < 32; i++) prog[i] = 8'h00;
        prog[0] = 8'h20; prog[2] = 8'hE4; prog[4] = 8'h20; prog[6] = 8'hFC;
        prog[28] = 8'hFF; prog[31] = 8'hBD; prog[29] = 8'h01;
        exp_path[0] = 5'h00; exp_path[1] = 5'h02; exp_path[2] = 5'h04; exp_path[3] = 5'h06;
        exp_path[4] = 5'h1C; exp_path[5] = 5'h1F; exp_path[6] = 5'h1D; exp_path[7] = 5'h00;
        exp_path[8] = 5'h01;
        start(0, 50);
        run_to_end(cyc);
        check("p4_len", log_addr.size(), 9);
        for (int i = 0; i < 9 && i < log_addr.size(); i++) check("p4_path", log_addr[i], exp_path[i]);
        check("p4_acc", acc_out, 8'h01);

        // ADD carry dropped, XOR with itself clears.
        for (int i = 0; i < 32; i++) prog[i] = 8'h00;
        prog[0] = 8'hB0; prog[1] = 8'h51; prog[2] = 8'h92;
        prog[16] = 8'hF0; prog[17] = 8'h20; prog[18] = 8'h10;
        start(-1, 50);
        run_to_end(cyc);
        check("p5_len", log_acc.size(), 7);
        if (log_acc.size() > 4) check("p5_add_acc", log_acc[4], 8'h10);
        check("p5_acc", acc_out, 8'h00);

        // Reset while the ADD operand read is stalled.
        load_prog2();
        start(3, 50);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(posedge clk); #1;
            if (mem_req && mem_addr == 5'h1F) found = 1'b1;
        end
        check("p6_found", found, 1'b1);
        check("p6_acc_before", acc_out, 8'h12);
        chk_on = 1'b0;
        rst = 1'b1;
        #1;
        check("p6_req_drop", mem_req, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        check("p6_req", mem_req, 1'b1);
        check("p6_addr", mem_addr, 5'h00);
        check("p6_acc", acc_out, 8'h00);

        // Random programs, random or zero wait states.
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 32; i++) begin
                prog[i] = 8'($urandom);
                if ($urandom_range(0, 7) == 0) prog[i] = 8'h00;
            end
            start((r % 2 == 0) ? -1 : 0, 30);
            run_to_end(cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
